// File: rtl/soc_reset_seq_if.sv
// Reset sequencer bus: request inputs toward the sequencer,
// staged resets and firmware status back out.
interface soc_reset_seq_if #(
  parameter int NUM_SRC = 4,
  parameter int NUM_OUT = 3
);
  logic               pll_locked;
  logic [NUM_SRC-1:0] src_req;
  logic [NUM_SRC-1:0] cause_clr;
  logic [NUM_OUT-1:0] rst_out;
  logic               busy;
  logic [NUM_SRC-1:0] cause;
  logic [7:0]         rst_count;

  modport master (
    output pll_locked, src_req, cause_clr,
    input  rst_out, busy, cause, rst_count
  );

  modport slave (
    input  pll_locked, src_req, cause_clr,
    output rst_out, busy, cause, rst_count
  );
endinterface

// File: rtl/soc_reset_seq.sv
// SoC reset sequencer: merges request sources and PLL lock into one
// stretched reset event, then releases ordered domains one by one.
module soc_reset_seq #(
  parameter int NUM_SRC     = 4,
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter logic [NUM_SRC-1:0] SRC_ACTIVE_LOW = 4'b0010,
  parameter logic [NUM_SRC-1:0] SRC_EDGE       = 4'b0000
) (
  input logic            clk,
  input logic            rst,
  soc_reset_seq_if.slave bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int KW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_INIT  = GW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    S_ASSERT,
    S_RELEASE,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [KW-1:0]      k_q, k_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               busy_q, busy_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [7:0]         count_q, count_d;
  logic [NUM_SRC-1:0] act;
  logic [NUM_SRC-1:0] trig;
  logic               t;

  always_comb begin
    act  = bus.src_req ^ SRC_ACTIVE_LOW;
    trig = act & (~SRC_EDGE | ~prev_q);
    t    = (|trig) | ~bus.pll_locked;

    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    k_d       = k_q;
    rst_out_d = rst_out_q;
    count_d   = count_q;
    prev_d    = act;
    // set beats clear when both land on the same edge
    cause_d   = (cause_q & ~bus.cause_clr) | trig;

    if (t) begin
      state_d   = S_ASSERT;
      hold_d    = HOLD_INIT;
      rst_out_d = '1;
      if (state_q != S_ASSERT && count_q != 8'hff)
        count_d = count_q + 8'd1;
    end else begin
      unique case (state_q)
        S_ASSERT: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
          end else begin
            rst_out_d[0] = 1'b0;
            gap_d        = GAP_INIT;
            k_d          = KW'(1);
            state_d      = (NUM_OUT == 1) ? S_RUN : S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
          end else begin
            for (int i = 0; i < NUM_OUT; i++)
              if (i == int'(k_q)) rst_out_d[i] = 1'b0;
            gap_d = GAP_INIT;
            k_d   = k_q + KW'(1);
            if (int'(k_q) == NUM_OUT - 1) state_d = S_RUN;
          end
        end
        default: ;
      endcase
    end

    busy_d = |rst_out_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ASSERT;
      hold_q    <= HOLD_INIT;
      gap_q     <= GAP_INIT;
      k_q       <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      cause_q   <= '0;
      prev_q    <= '1;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      k_q       <= k_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
      prev_q    <= prev_d;
      count_q   <= count_d;
    end
  end

  assign bus.rst_out   = rst_out_q;
  assign bus.busy      = busy_q;
  assign bus.cause     = cause_q;
  assign bus.rst_count = count_q;

endmodule
